// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two valid/ready requesters.
// Optional per-port grant counters: define ALU_SHARE_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_op,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [WIDTH-1:0]   resp_result,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_err;
    logic [1:0]         r_resp_valid;

    logic               w_any;
    logic               w_win;
    logic               w_accept;
    logic               w_op_legal;
    logic               w_resp_done;

    always_comb begin
        w_any = |req_valid;
        // On contention the port that was not served last wins
        if (req_valid == 2'b11) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = req_valid[1];
        end
        req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            req_ready[w_win] = 1'b1;
        end
        w_accept    = (r_state == S_IDLE) && w_any;
        w_op_legal  = (r_op[1:0] != 2'b11);
        w_resp_done = (r_state == S_RESP) && resp_ready[r_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 3'b000;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        r_b          <= w_win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        r_op         <= w_win ? req_op[5:3] : req_op[2:0];
                        r_id         <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op_legal) begin
                        r_result <= alu_result;
                        r_zero   <= alu_zero;
                        r_err    <= 1'b0;
                    end else begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_err    <= 1'b1;
                    end
                    r_resp_valid <= {r_id, ~r_id};
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand registers only change on accept, so the ALU inputs stay quiet while idle
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign resp_err    = r_err;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_win && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_win && r_cnt1 != 16'hFFFF)  r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases then randomized traffic
// checked against a transaction-level model (grant order, result, latency, stability).
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp_result;
    logic           resp_zero;
    logic           resp_err;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_zero;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0]    grant_cnt0;
    logic [15:0]    grant_cnt1;
`endif

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
`ifdef ALU_SHARE_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in ALU; drives junk on illegal codes so the arbiter must ignore it
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b100: alu_result = alu_a - alu_b;
            3'b001: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b010: alu_result = alu_a ^ alu_b;
            3'b110: alu_result = {alu_b[15:0], 16'h0000};
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_op == 3'b011 || alu_op == 3'b111) ? 1'b0 : (alu_result == '0);
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_last;
    int          m_cnt [2];
    logic [31:0] f_a   [2];
    logic [31:0] f_b   [2];
    logic [2:0]  f_op  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd4: return a - b;
            3'd1: return a & b;
            3'd5: return a | b;
            3'd2: return a ^ b;
            3'd6: return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op);
        f_a[p]  = a;
        f_b[p]  = b;
        f_op[p] = op;
        req_a[p*32 +: 32] = a;
        req_b[p*32 +: 32] = b;
        req_op[p*3 +: 3]  = op;
        req_valid[p]      = 1'b1;
    endtask

    // Runs one complete transaction from IDLE; returns the port the DUT granted.
    task automatic serve(input int hold, output int granted);
        int          w;
        logic [1:0]  oh;
        logic [31:0] er;
        logic        ee;
        logic        ez;
        #1;
        if (req_valid == 2'b11) w = 1 - m_last;
        else                    w = req_valid[1] ? 1 : 0;
        oh = (w == 1) ? 2'b10 : 2'b01;
        granted = req_ready[1] ? 1 : 0;
        chk("grant", {62'd0, req_ready}, {62'd0, oh});
        ee = (f_op[w][1:0] == 2'b11);
        er = ee ? 32'd0 : model_res(f_op[w], f_a[w], f_b[w]);
        ez = ee ? 1'b1 : (er == 32'd0);
        @(posedge clk);
        m_last = w;
        if (m_cnt[w] < 65535) m_cnt[w]++;
        @(negedge clk);
        chk("exec_ready", {62'd0, req_ready}, 64'd0);
        chk("exec_rvalid", {62'd0, resp_valid}, 64'd0);
        chk("alu_a", {32'd0, alu_a}, {32'd0, f_a[w]});
        chk("alu_b", {32'd0, alu_b}, {32'd0, f_b[w]});
        chk("alu_op", {61'd0, alu_op}, {61'd0, f_op[w]});
`ifdef ALU_SHARE_ARB_STATS_EN
        chk("cnt0", {48'd0, grant_cnt0}, m_cnt[0]);
        chk("cnt1", {48'd0, grant_cnt1}, m_cnt[1]);
`endif
        req_valid[w] = 1'b0;
        @(negedge clk);
        chk("rvalid_T2", {62'd0, resp_valid}, {62'd0, oh});
        chk("result", {32'd0, resp_result}, {32'd0, er});
        chk("zero", {63'd0, resp_zero}, {63'd0, ez});
        chk("err", {63'd0, resp_err}, {63'd0, ee});
        // While the owner stalls, assert ready on the other port only
        resp_ready = (hold > 0) ? ~oh : oh;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rvalid", {62'd0, resp_valid}, {62'd0, oh});
            chk("hold_result", {32'd0, resp_result}, {32'd0, er});
            chk("hold_flags", {62'd0, resp_zero, resp_err}, {62'd0, ez, ee});
            chk("hold_ready", {62'd0, req_ready}, 64'd0);
        end
        resp_ready = oh;
        @(negedge clk);
        resp_ready = 2'b00;
        chk("done_rvalid", {62'd0, resp_valid}, 64'd0);
        #1;
        chk("idle_ready", {63'd0, req_ready != 2'b00}, {63'd0, req_valid != 2'b00});
    endtask

    initial begin
        int g;
        int order [4];
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '0;
        m_last     = 1;
        m_cnt[0]   = 0;
        m_cnt[1]   = 0;
        for (int p = 0; p < 2; p++) begin
            f_a[p] = '0; f_b[p] = '0; f_op[p] = '0;
        end
        #12;
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rst_result", {32'd0, resp_result}, 64'd0);
        chk("rst_flags", {62'd0, resp_zero, resp_err}, 64'd0);
        chk("rst_alu", {alu_a, alu_b}, 64'd0);
        chk("rst_alu_op", {61'd0, alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_port(0, 32'd5, 32'd3, 3'b000);
        serve(0, g);
        set_port(1, 32'd7, 32'd7, 3'b100);
        serve(0, g);
        set_port(1, 32'd0, 32'h0000ABCD, 3'b110);
        serve(0, g);
        set_port(0, 32'h1234, 32'h55, 3'b011);
        serve(0, g);
        set_port(0, 32'hF0F0, 32'h0FF0, 3'b101);
        serve(5, g);

        // Reset in the middle of EXEC discards the op
        set_port(0, 32'd1, 32'd2, 3'b000);
        #1;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_rvalid", {62'd0, resp_valid}, 64'd0);
        chk("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
        #2;
        rst_n    = 1'b1;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {62'd0, resp_valid}, 64'd0);
        end

        set_port(0, 32'd10, 32'd20, 3'b000);
        set_port(1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b001);
        for (int i = 0; i < 4; i++) begin
            serve(0, g);
            order[i] = g;
            if (i < 3) begin
                if (g == 0) set_port(0, 32'd10 + i, 32'd20, 3'b010);
                else        set_port(1, 32'd30 + i, 32'd4, 3'b100);
            end
        end
        chk("order0", order[0], 64'd0);
        chk("order1", order[1], 64'd1);
        chk("order2", order[2], 64'd0);
        chk("order3", order[3], 64'd1);
`ifdef ALU_SHARE_ARB_STATS_EN
        chk("stats_cnt0", {48'd0, grant_cnt0}, 64'd2);
        chk("stats_cnt1", {48'd0, grant_cnt1}, 64'd2);
`endif
        req_valid = '0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 1) == 1)
                    set_port(p, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                             3'($urandom_range(0, 7)));
            end
            if (req_valid == 2'b00) begin
                set_port($urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            serve($urandom_range(0, 3), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
